// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory program loader.
// Optional checksum trailer is enabled by defining INSTR_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = HDR_BYTES * BYTE_W;
  localparam int unsigned PACK_CNT_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles accepted bytes MSB-first into 32-bit words; word_valid_c flags the 4th byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  localparam int unsigned PART_W = WORD_W - BYTE_W;

  logic [PART_W-1:0]     partial;
  logic [PACK_CNT_W-1:0] cnt;

  // The incoming byte completes the word combinationally so the write can issue next edge.
  assign word_c       = {partial, byte_data};
  assign word_valid_c = accept && (cnt == PACK_CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      partial <= '0;
      cnt     <= '0;
    end else if (accept) begin
      partial <= word_c[PART_W-1:0];
      cnt     <= cnt + PACK_CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: writes big-endian words to instruction memory, then releases CPU start.
// Define INSTR_LOADER_CHECKSUM_EN to require an XOR checksum byte after the data.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              error_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state, state_next;
  logic               ready_next, busy_next;
  logic               accept_c, enter_hdr0_c, last_word_c;
  logic [BYTE_W-1:0]  cnt_hi;
  logic [CNT_W-1:0]   count, hdr_count_c;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  word_c;
  logic               word_valid_c;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  csum;
`endif

  assign accept_c     = byte_valid_i && byte_ready_o;
  assign hdr_count_c  = {cnt_hi, byte_i};
  assign enter_hdr0_c = (state_next == HDR0) && (state != HDR0);
  assign last_word_c  = (CNT_W'(idx) == count - CNT_W'(1));

  byte_packer u_packer (
    .clk          (clk_i),
    .clear        (rst_i || enter_hdr0_c),
    .accept       (accept_c && (state == DATA)),
    .byte_data    (byte_i),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_next = 1'b0;
    busy_next  = 1'b0;
    case (state)
      IDLE: if (load_req_i) state_next = HDR0;
      HDR0: if (accept_c) state_next = HDR1;
      HDR1: begin
        if (accept_c) begin
          if (hdr_count_c == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else if (hdr_count_c > CNT_W'(DEPTH)) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (word_valid_c && last_word_c) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM: if (accept_c) state_next = (byte_i == csum) ? DONE : ERR;
`endif
      DONE, ERR: if (load_req_i) state_next = HDR0;
      default: state_next = IDLE;
    endcase
    // Handshake/busy flags track the state being entered so they are registered yet current.
    case (state_next)
      HDR0, HDR1, DATA, CSUM: begin
        ready_next = 1'b1;
        busy_next  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
      start_o      <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      idx          <= '0;
      cnt_hi       <= '0;
      count        <= '0;
    end else begin
      byte_ready_o <= ready_next;
      busy_o       <= busy_next;
      error_o      <= (state_next == ERR);
      // Start lags DONE entry by a cycle so the last write lands first, but drops with the exit.
      start_o      <= (state == DONE) && (state_next == DONE);
      wr_en_o      <= word_valid_c;
      if (word_valid_c) begin
        wr_addr_o <= ADDR_W'({idx, 2'b00});
        wr_data_o <= word_c;
        if (!last_word_c) idx <= idx + IDX_W'(1);
      end
      if (accept_c && (state == HDR0)) cnt_hi <= byte_i;
      if (accept_c && (state == HDR1)) count  <= hdr_count_c;
      if (enter_hdr0_c) idx <= '0;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // XOR of every accepted header and data byte.
  always_ff @(posedge clk_i) begin
    if (rst_i || enter_hdr0_c) csum <= '0;
    else if (accept_c && (state == HDR0 || state == HDR1 || state == DATA)) csum <= csum ^ byte_i;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and random images against an image-level model.
module tb_instr_loader;

  localparam int unsigned DEPTH = 256;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_req_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o, wr_en_o, start_o, busy_o, error_o;
  logic [31:0] wr_addr_o, wr_data_o;

  always #5 clk = ~clk;

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_req_i   (load_req_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .error_o      (error_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          last_wr_cyc = -1;
  int          start_rise_cyc = -1;
  int          data_changes = 0;
  logic        prev_start = 1'b0;
  logic [31:0] held_data = '0;

  logic [7:0]  img[$];
  logic        gap = 1'b0;
  logic        req_err, req_busy, req_start;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en_o) begin
      obs_addr.push_back(wr_addr_o);
      obs_data.push_back(wr_data_o);
      last_wr_cyc = cyc;
      held_data   = wr_data_o;
    end else if (wr_data_o !== held_data) begin
      data_changes++;
      held_data = wr_data_o;
    end
    if (start_o && !prev_start) start_rise_cyc = cyc;
    prev_start = start_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    obs_addr.delete();
    obs_data.delete();
    last_wr_cyc    = -1;
    start_rise_cyc = -1;
    data_changes   = 0;
  endtask

  // Builds a random image of n words; bad_csum corrupts the trailer when checksums are on.
  task automatic make_img(input int n, input bit bad_csum);
    logic [7:0] x;
    img.delete();
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    if (n <= int'(DEPTH)) begin
      for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
      if (CSUM_EN) begin
        x = '0;
        foreach (img[i]) x ^= img[i];
        img.push_back(bad_csum ? x ^ 8'(1 + $urandom_range(0, 254)) : x);
      end
    end
  endtask

  // Pulses load_req_i, then streams img[0..limit-1] through the handshake.
  task automatic send_img(input int limit, input bit tail);
    bit rdy;
    int bound;
    @(posedge clk); #1 load_req_i = 1'b1;
    @(posedge clk); #1 load_req_i = 1'b0;
    req_err   = error_o;
    req_busy  = busy_o;
    req_start = start_o;
    for (int i = 0; i < limit && i < img.size(); i++) begin
      if (gap && i > 0) begin
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_valid_i = 1'b1;
      byte_i = img[i];
      bound = 0;
      do begin
        rdy = byte_ready_o;
        @(posedge clk); #1;
        bound++;
      end while (!rdy && bound < 50);
      if (!rdy) check("accept_timeout", 32'(i), 32'hFFFF_FFFF);
    end
    byte_valid_i = 1'b0;
    if (tail) begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  // Image-level model: expected writes and outcome derived from the byte list alone.
  task automatic check_load(input string tag);
    int n;
    int nw;
    bit exp_err;
    logic [7:0] x;
    logic [31:0] w;
    n  = {img[0], img[1]};
    exp_err = n > int'(DEPTH);
    nw = exp_err ? 0 : n;
    if (!exp_err && CSUM_EN) begin
      x = '0;
      for (int i = 0; i < 2 + 4 * n; i++) x ^= img[i];
      exp_err = (img[2 + 4 * n] != x);
    end
    check({tag, ".req_busy"},  32'(req_busy), 32'd1);
    check({tag, ".req_err"},   32'(req_err), 32'd0);
    check({tag, ".req_start"}, 32'(req_start), 32'd0);
    check({tag, ".nwrites"},   32'(obs_addr.size()), 32'(nw));
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      w = {img[2 + 4 * i], img[3 + 4 * i], img[4 + 4 * i], img[5 + 4 * i]};
      check({tag, ".addr"}, obs_addr[i], 32'(4 * i));
      check({tag, ".data"}, obs_data[i], w);
    end
    check({tag, ".error"}, 32'(error_o), 32'(exp_err));
    check({tag, ".start"}, 32'(start_o), 32'(!exp_err));
    check({tag, ".busy"},  32'(busy_o), 32'd0);
    check({tag, ".ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, ".data_hold"}, 32'(data_changes), 32'd0);
`ifndef INSTR_LOADER_CHECKSUM_EN
    if (nw > 0) check({tag, ".start_lat"}, 32'(start_rise_cyc), 32'(last_wr_cyc + 1));
`endif
  endtask

  task automatic run(input string tag, input bit g);
    gap = g;
    clear_mon();
    send_img(img.size(), 1'b1);
    check_load(tag);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(byte_ready_o), 32'd0);
    check("rst.wr_en", 32'(wr_en_o), 32'd0);
    check("rst.start", 32'(start_o), 32'd0);
    check("rst.busy",  32'(busy_o), 32'd0);
    check("rst.error", 32'(error_o), 32'd0);
    check("rst.addr",  wr_addr_o, 32'd0);
    check("rst.data",  wr_data_o, 32'd0);
    rst_i = 1'b0;

    // Directed N=2, back-to-back then with gaps
    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    if (CSUM_EN) img.push_back(8'h00 ^ 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
    run("n2", 1'b0);
    check("n2.w1_data", (obs_data.size() > 1) ? obs_data[1] : 32'hX, 32'h9ABC_DEF0);
    run("n2gap", 1'b1);
    check("n2gap.w0_data", (obs_data.size() > 0) ? obs_data[0] : 32'hX, 32'h1234_5678);

    // Empty image and oversize count
    make_img(0, 1'b0);
    run("n0", 1'b0);
    make_img(257, 1'b0);
    run("n257", 1'b0);
    check("n257.start_stays", 32'(start_rise_cyc), 32'hFFFF_FFFF);

    // Random images
    for (int t = 0; t < 8; t++) begin
      make_img(int'($urandom_range(1, 8)), 1'($urandom_range(0, 3) == 0));
      run("rand", 1'($urandom_range(0, 1)));
    end

    // Full memory: last word lands at 0x3FC
    make_img(int'(DEPTH), 1'b0);
    run("full", 1'b0);
    check("full.last_addr", (obs_addr.size() > 0) ? obs_addr[obs_addr.size() - 1] : 32'hX, 32'h0000_03FC);

`ifdef INSTR_LOADER_CHECKSUM_EN
    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run("csum_ok", 1'b0);
    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    run("csum_bad", 1'b0);
`endif

    // Reset after 6 data bytes
    make_img(2, 1'b0);
    gap = 1'b0;
    clear_mon();
    send_img(2 + 6, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("mid.ready", 32'(byte_ready_o), 32'd0);
    check("mid.wr_en", 32'(wr_en_o), 32'd0);
    check("mid.start", 32'(start_o), 32'd0);
    check("mid.busy",  32'(busy_o), 32'd0);
    check("mid.error", 32'(error_o), 32'd0);
    check("mid.addr",  wr_addr_o, 32'd0);
    check("mid.data",  wr_data_o, 32'd0);
    check("mid.nwrites", 32'(obs_addr.size()), 32'd1);
    check("mid.w0", (obs_data.size() > 0) ? obs_data[0] : 32'hX, {img[2], img[3], img[4], img[5]});
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid.start_after", 32'(start_o), 32'd0);
    check("mid.nwrites_after", 32'(obs_addr.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the instruction memory read by the CPU fetch path. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and issues one write per word at consecutive byte addresses starting at 0. It holds the CPU's `start_i` low until the program image is fully written. It sits between the host/boot byte source and the instruction memory write port, and drives the CPU start.

## Interface
- `DEPTH`, 256, instruction memory capacity in 32-bit words; the largest legal word count.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `load_req_i` input 1: start a new load; level-sampled each cycle.
- `byte_i` input 8: stream byte.
- `byte_valid_i` input 1: `byte_i` is valid.
- `byte_ready_o` output 1: loader accepts a byte this cycle.
- `wr_en_o` output 1: instruction memory write strobe, one cycle per word.
- `wr_addr_o` output 32: write byte address, word-aligned.
- `wr_data_o` output 32: write data.
- `start_o` output 1: drives the CPU `start_i`.
- `busy_o` output 1: a load is in progress.
- `error_o` output 1: the last load failed.

## Operation
- Accept a byte when `byte_valid_i && byte_ready_o`.
  - `byte_ready_o` is 1 only in HDR0, HDR1, DATA and CSUM.
- Image format, in order:
  - 2-byte word count N, big-endian.
  - 4N data bytes, each word big-endian (MSB first).
  - Optional checksum byte; see Configuration.
- States and transitions:
  - IDLE: on `load_req_i`, go to HDR0.
  - HDR0: accept the count high byte, go to HDR1.
  - HDR1: accept the count low byte.
    - N == 0: go to CSUM if enabled, else DONE.
    - N > DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: accept bytes and shift them into the word. On the 4th byte, issue the write and increment the word index.
    - After word N: go to CSUM if enabled, else DONE.
  - DONE: `start_o` = 1 and `busy_o` = 0. On `load_req_i`, go to HDR0.
  - ERR: `error_o` = 1 and `start_o` = 0. On `load_req_i`, go to HDR0.
- `load_req_i` is ignored in HDR0, HDR1, DATA and CSUM.
- Entering HDR0 clears:
  - `error_o`
  - `start_o`
  - the word index
  - the checksum accumulator
- Address rule: `wr_addr_o` = word index × 4, i.e. `{index, 2'b00}` zero-extended to 32 bits.
  - The index never exceeds DEPTH−1, so there is no wrap-around.
- `busy_o` = 1 in HDR0, HDR1, DATA and CSUM.

## Timing
- Reset values:
  - state = IDLE.
  - `byte_ready_o`, `wr_en_o`, `start_o`, `busy_o` and `error_o` = 0.
  - `wr_addr_o` and `wr_data_o` = 0.
- Reset mid-load forces IDLE on the next edge.
  - Words already written stay written.
  - `start_o` stays 0.
- Throughput is one byte per cycle.
  - `byte_ready_o` is a registered function of state only, so it does not depend on `byte_valid_i` in the same cycle.
- Write latency: `wr_en_o` pulses for exactly 1 cycle, in the cycle after the 4th byte of a word is accepted.
  - `wr_addr_o` and `wr_data_o` are valid during that pulse and hold until the next write.
- The transition to DONE happens on the same edge as the last write pulse begins.
  - Therefore `start_o` rises 1 cycle after the final `wr_en_o` pulse starts.
  - This guarantees the memory write lands before the CPU fetches.
- `load_req_i` in DONE or ERR: `start_o` falls and `busy_o` rises on the next edge.
- Stalls: with `byte_valid_i` = 0, the state, the partial word and the index hold.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - The CSUM state exists.
  - An 8-bit accumulator XORs every accepted header and data byte.
  - The received checksum byte must equal the accumulator → DONE; otherwise → ERR.
- Not defined:
  - The CSUM state and the accumulator are absent.
  - HDR1 (N == 0) and DATA (last word) go directly to DONE.
  - No trailing byte is consumed.

## Structure
- Package `instr_loader_pkg`:
  - state enum: IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR.
  - header length constant `HDR_BYTES` = 2.
  - bytes-per-word constant = 4.
- Sub-module `byte_packer`:
  - 32-bit shift register with a 2-bit byte counter.
  - `word_valid` pulses on the 4th byte.
  - Synchronous clear.

## Test plan
- Load N = 2 with bytes 00 02 | 12 34 56 78 | 9A BC DE F0, valid every cycle.
  - Two writes: (addr 0x0, data 0x12345678) and (addr 0x4, data 0x9ABCDEF0).
  - `start_o` rises 1 cycle after the second write pulse begins.
- Same image with `byte_valid_i` toggling every other cycle.
  - Identical writes; no extra `wr_en_o` pulses; `wr_data_o` is stable between writes.
- N = 0 (bytes 00 00).
  - No writes; DONE; `start_o` = 1.
- N = 257 with DEPTH = 256 (bytes 01 01).
  - ERR; `error_o` = 1; `start_o` = 0; `byte_ready_o` = 0.
  - A later `load_req_i` clears `error_o`.
- `rst_i` asserted after 6 data bytes.
  - Next cycle: all outputs are at their reset values.
  - Word 0 was written; word 1 was not; `start_o` stays 0.
- Checksum enabled, N = 1, bytes 00 01 | 01 02 03 04 | checksum.
  - Checksum 0x05 → DONE.
  - Checksum 0x06 → ERR with `start_o` = 0.
